mac_array_pipe: RTL and testbench

//  Parametrised, pipelined N-lane dot-product MAC: each accepted beat multiplies LANES x/w pairs,

---
 rtl/mac_array_pipe_pkg.sv | 15 +
 rtl/mac_array_pipe_adder_tree.sv | 25 ++
 rtl/mac_array_pipe.sv | 159 +++++++++++++++
 tb/tb_mac_array_pipe.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mac_array_pipe_pkg.sv
// Shared defaults and sizing helpers for the pipelined dot-product MAC.
// Imported by the top and the adder-tree sub-module.
package mac_array_pipe_pkg;

  localparam int DEF_BW      = 4;
  localparam int DEF_PSUM_BW = 16;
  localparam int DEF_LANES   = 4;
  localparam int DEF_ACC_LEN = 4;

  // Beat counter needs at least one bit even when a group is a single beat.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_array_pipe_adder_tree.sv
// Combinational binary adder tree: LANES psum_bw terms -> one psum_bw sum, modulo 2^psum_bw.
// Zero latency; no flow control (pure function of its inputs).
module mac_array_pipe_adder_tree
  import mac_array_pipe_pkg::*;
#(
  parameter int psum_bw = DEF_PSUM_BW,
  parameter int LANES   = DEF_LANES
) (
  input  logic [LANES*psum_bw-1:0] terms,
  output logic [psum_bw-1:0]       sum
);

  // Heap layout: leaves at LANES-1 .. 2*LANES-2, node k sums children 2k+1 and 2k+2.
  always_comb begin : tree
    logic [psum_bw-1:0] node [2*LANES-1];
    for (int i = 0; i < LANES; i++) begin
      node[LANES-1+i] = terms[i*psum_bw +: psum_bw];
    end
    for (int k = LANES - 2; k >= 0; k--) begin
      node[k] = node[2*k+1] + node[2*k+2];
    end
    sum = node[0];
  end

endmodule

// File: rtl/mac_array_pipe.sv
// Pipelined LANES-wide dot-product MAC accumulating ACC_LEN beats per group onto a seed; result 3 cycles after last beat.
// Whole pipeline stalls while a result is held unconsumed; in_ready = !out_valid || out_ready.
module mac_array_pipe
  import mac_array_pipe_pkg::*;
#(
  parameter int bw      = DEF_BW,
  parameter int psum_bw = DEF_PSUM_BW,
  parameter int LANES   = DEF_LANES,
  parameter int ACC_LEN = DEF_ACC_LEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [LANES*bw-1:0]   x,
  input  logic [LANES*bw-1:0]   w,
  input  logic [psum_bw-1:0]    psum_in,
  input  logic                  is_signed,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [psum_bw-1:0]    out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int              CW       = cnt_width(ACC_LEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(ACC_LEN - 1);

  logic                     adv, accept, beat_first, beat_last;
  logic [LANES*psum_bw-1:0] prod;
  logic [psum_bw-1:0]       tree_sum, acc_sum;

  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [psum_bw-1:0]       s1_seed_q, s1_seed_d;
  logic [LANES*psum_bw-1:0] s1_prod_q, s1_prod_d;
  logic                     s2_vld_q, s2_vld_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic [psum_bw-1:0]       s2_seed_q, s2_seed_d, s2_sum_q, s2_sum_d;
  logic                     s3_vld_q, s3_vld_d, s3_last_q, s3_last_d;
  logic [psum_bw-1:0]       acc_q, acc_d;
  logic [psum_bw-1:0]       out_q, out_d;
  logic                     out_valid_q, out_valid_d;

  // Operands are extended to full width before multiplying, so the low psum_bw bits are exact in both modes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [bw-1:0]      xl, wl;
    logic [psum_bw-1:0] xe, we;
    assign xl = x[i*bw +: bw];
    assign wl = w[i*bw +: bw];
    assign xe = {{(psum_bw-bw){is_signed & xl[bw-1]}}, xl};
    assign we = {{(psum_bw-bw){is_signed & wl[bw-1]}}, wl};
    assign prod[i*psum_bw +: psum_bw] = xe * we;
  end

  mac_array_pipe_adder_tree #(
    .psum_bw (psum_bw),
    .LANES   (LANES)
  ) u_tree (
    .terms (s1_prod_q),
    .sum   (tree_sum)
  );

  always_comb begin
    adv        = !out_valid_q || out_ready;
    accept     = in_valid && adv;
    beat_first = (cnt_q == '0);
    beat_last  = (cnt_q == CNT_LAST);
    acc_sum    = (s2_first_q ? s2_seed_q : acc_q) + s2_sum_q;

    cnt_d       = cnt_q;
    s1_vld_d    = s1_vld_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_seed_d   = s1_seed_q;
    s1_prod_d   = s1_prod_q;
    s2_vld_d    = s2_vld_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    s2_seed_d   = s2_seed_q;
    s2_sum_d    = s2_sum_q;
    s3_vld_d    = s3_vld_q;
    s3_last_d   = s3_last_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      cnt_d = beat_last ? '0 : cnt_q + 1'b1;
    end

    if (adv) begin
      s1_vld_d   = accept;
      s1_first_d = beat_first;
      s1_last_d  = beat_last;
      s1_seed_d  = psum_in;
      s1_prod_d  = prod;
      s2_vld_d   = s1_vld_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_seed_d  = s1_seed_q;
      s2_sum_d   = tree_sum;
      s3_vld_d   = s2_vld_q;
      s3_last_d  = s2_vld_q && s2_last_q;
      // Bubbles leave the accumulator untouched.
      if (s2_vld_q) begin
        acc_d = acc_sum;
      end
      if (s3_vld_q && s3_last_q) begin
        out_d       = acc_q;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_seed_q   <= '0;
      s1_prod_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_seed_q   <= '0;
      s2_sum_q    <= '0;
      s3_vld_q    <= 1'b0;
      s3_last_q   <= 1'b0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_seed_q   <= s1_seed_d;
      s1_prod_q   <= s1_prod_d;
      s2_vld_q    <= s2_vld_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_seed_q   <= s2_seed_d;
      s2_sum_q    <= s2_sum_d;
      s3_vld_q    <= s3_vld_d;
      s3_last_q   <= s3_last_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = adv;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = s1_vld_q || s2_vld_q || s3_vld_q || out_valid_q || (cnt_q != '0);

endmodule

// File: tb/tb_mac_array_pipe.sv
// Directed self-checking bench: one single-beat-group instance and one four-beat-group instance share stimulus.
module tb_mac_array_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] x, w, psum_in;
  logic        is_signed, out_ready;
  logic        in_valid1, in_valid4;
  logic        in_ready1, out_valid1, busy1;
  logic        in_ready4, out_valid4, busy4;
  logic [15:0] out1, out4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_array_pipe #(.bw(4), .psum_bw(16), .LANES(4), .ACC_LEN(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .x(x), .w(w), .psum_in(psum_in), .is_signed(is_signed),
    .in_valid(in_valid1), .in_ready(in_ready1), .out(out1), .out_valid(out_valid1),
    .out_ready(out_ready), .busy(busy1)
  );

  mac_array_pipe #(.bw(4), .psum_bw(16), .LANES(4), .ACC_LEN(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .x(x), .w(w), .psum_in(psum_in), .is_signed(is_signed),
    .in_valid(in_valid4), .in_ready(in_ready4), .out(out4), .out_valid(out_valid4),
    .out_ready(out_ready), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out4(input string tag, input logic [15:0] exp);
    int n = 0;
    while (!out_valid4 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, {31'd0, out_valid4}, 32'd1);
    chk(tag, {16'd0, out4}, {16'd0, exp});
  endtask

  initial begin
    reset_n = 1'b0; x = '0; w = '0; psum_in = '0; is_signed = 1'b0;
    out_ready = 1'b1; in_valid1 = 1'b0; in_valid4 = 1'b0;
    #3;
    chk("rst_out1", {16'd0, out1}, 32'd0);
    chk("rst_ovld1", {31'd0, out_valid1}, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_rdy1", {31'd0, in_ready1}, 32'd1);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk("rst_rdy4", {31'd0, in_ready4}, 32'd1);
    #8 reset_n = 1'b1;
    step();

    // Single-beat group: 1+4+9+16 + 10 = 40, three cycles after accept.
    x = 16'h4321; w = 16'h4321; psum_in = 16'd10; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("t1_lat0", {31'd0, out_valid1}, 32'd0);
    step();
    chk("t1_lat1", {31'd0, out_valid1}, 32'd0);
    step();
    chk("t1_lat2", {31'd0, out_valid1}, 32'd0);
    step();
    chk("t1_lat3", {31'd0, out_valid1}, 32'd1);
    chk("t1_out", {16'd0, out1}, 32'd40);
    step();
    chk("t1_clr", {31'd0, out_valid1}, 32'd0);

    // Signed: 4 beats of 4*(-1*2) = -32.
    is_signed = 1'b1; x = 16'hFFFF; w = 16'h2222; psum_in = 16'd0; in_valid4 = 1'b1;
    step();
    step();
    chk("t2_busy_mid", {31'd0, busy4}, 32'd1);
    step();
    step();
    in_valid4 = 1'b0;
    wait_out4("t2_signed", 16'hFFE0);
    step();
    chk("t2_clr", {31'd0, out_valid4}, 32'd0);
    chk("t2_idle", {31'd0, busy4}, 32'd0);
    // Same data unsigned: 4 beats of 4*30 = 480.
    is_signed = 1'b0; in_valid4 = 1'b1;
    repeat (4) step();
    in_valid4 = 1'b0;
    wait_out4("t2_unsigned", 16'd480);
    step();

    // Backpressure on single-beat groups: each result = seed + 4.
    out_ready = 1'b0; x = 16'h1111; w = 16'h1111;
    for (int k = 0; k < 4; k++) begin
      psum_in = 16'(100 * (k + 1)); in_valid1 = 1'b1;
      chk("t3_rdy_fill", {31'd0, in_ready1}, 32'd1);
      step();
    end
    psum_in = 16'd500;
    chk("t3_vld", {31'd0, out_valid1}, 32'd1);
    chk("t3_out_a", {16'd0, out1}, 32'd104);
    chk("t3_rdy_low", {31'd0, in_ready1}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_hold_out", {16'd0, out1}, 32'd104);
      chk("t3_hold_rdy", {31'd0, in_ready1}, 32'd0);
      chk("t3_hold_busy", {31'd0, busy1}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    in_valid1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain_vld", {31'd0, out_valid1}, 32'd1);
      chk("t3_drain_out", {16'd0, out1}, 32'(200 + 100 * k + 4));
      step();
    end
    chk("t3_drain_end", {31'd0, out_valid1}, 32'd0);

    // Bubbles: beat k has lanes x=k+1, w=1 -> 4+8+12+16 + 7 = 47.
    w = 16'h1111; psum_in = 16'd7;
    for (int k = 0; k < 4; k++) begin
      x = 16'(16'h1111 * (k + 1)); in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      if (k < 3) begin
        step();
        chk("t4_gap_busy", {31'd0, busy4}, 32'd1);
        chk("t4_gap_novld", {31'd0, out_valid4}, 32'd0);
        step();
      end
    end
    wait_out4("t4_bubbles", 16'd47);
    step();

    // Overflow: 0xFFFF + 4*4*225 wraps to 0x0E0F.
    x = 16'hFFFF; w = 16'hFFFF; psum_in = 16'hFFFF; in_valid4 = 1'b1;
    repeat (4) step();
    in_valid4 = 1'b0;
    wait_out4("t5_wrap", 16'h0E0F);
    step();

    // Reset after 2 of 4 beats discards the partial group.
    x = 16'h1111; w = 16'h1111; psum_in = 16'd1000; in_valid4 = 1'b1;
    repeat (2) step();
    in_valid4 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_out", {16'd0, out4}, 32'd0);
    chk("t6_rst_vld", {31'd0, out_valid4}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy4}, 32'd0);
    chk("t6_rst_rdy", {31'd0, in_ready4}, 32'd1);
    #2 reset_n = 1'b1;
    step();
    psum_in = 16'd5; in_valid4 = 1'b1;
    step();
    step();
    chk("t6_partial", {31'd0, out_valid4}, 32'd0);
    step();
    step();
    in_valid4 = 1'b0;
    wait_out4("t6_clean", 16'd21);
    step();
    chk("t6_clr", {31'd0, out_valid4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
